cop0_exception_ctrl: RTL and testbench
======================================

// Module: cop0_exception_ctrl
// PURPOSE
//  Coprocessor-0 controller for the unpipelined MIPS core. Consumes the decoded
//  mtc0/mfc0/eret/unknown-func flags from the ALU control decoder plus ALU overflow.
//  Owns Status/Cause/EPC/Count/Compare and sequences exception entry, interrupt
//  entry and eret return. Drives PC redirect and writeback squash back to the datapath.
// PARAMETERS
//  EXC_VECTOR  32'h0000_0180  exception/interrupt entry PC
//  IRQ_W       5              hardware interrupt lines, mapped to Cause.IP[6:2]
// PORTS
//  i_clk        in   1   clock, all state on rising edge
//  i_rst_n      in   1   asynchronous active-low reset
//  i_valid      in   1   an instruction commits this cycle; qualifies all i_* flags
//  i_pc         in   32  PC of the committing instruction
//  i_mtc0       in   1   move-to-CP0
//  i_mfc0       in   1   move-from-CP0
//  i_eret       in   1   exception return
//  i_unknown    in   1   reserved/unknown instruction
//  i_overflow   in   1   signed ALU overflow (add/sub/addi)
//  i_cp0_addr   in   5   CP0 register number (rd field)
//  i_wdata      in   32  rt value for mtc0
//  i_irq        in   5   async hardware interrupt requests, level-sensitive
//  o_rdata      out  32  CP0 read data for mfc0 (combinational on i_cp0_addr)
//  o_redirect   out  1   PC mux select: load o_target next edge
//  o_target     out  32  EXC_VECTOR on entry, EPC on eret
//  o_squash     out  1   suppress regfile/memory write of the committing instruction
//  o_exl        out  1   Status.EXL
// BEHAVIOUR
//  Registers (addr): Count(9) Compare(11) Status(12) Cause(13) EPC(14); others read 0, writes ignored.
//  Reset values: Status=0, Cause=0, EPC=0, Count=0, Compare=32'hFFFF_FFFF; sync flops 0.
//  Status: IM[15:8], EXL[1], IE[0] writable; other bits read 0.
//  Cause: IP[15:8], ExcCode[6:2]; only IP[9:8] (soft ints) writable by mtc0.
//  IP[6:2] = i_irq after 2-flop synchroniser (2-cycle latency); IP[7] = timer pending.
//  int_pend = IE & ~EXL & |(IP & IM), evaluated from registered state.
//  Priority per valid cycle: exception > interrupt > eret > mtc0.
//   Exception (i_unknown: ExcCode=10 RI; i_overflow: ExcCode=12 Ov; RI wins if both):
//    redirect=1, target=EXC_VECTOR, squash=1; next edge EXL=1, ExcCode set, EPC=i_pc only if EXL was 0.
//   Interrupt (int_pend & i_valid, no exception): redirect, target=EXC_VECTOR, squash=1;
//    EPC=i_pc, EXL=1, ExcCode=0. Instruction at i_pc re-executes after eret.
//   Eret: redirect=1, target=EPC, squash=0; next edge EXL=0. Eret with EXL=0 still returns to EPC.
//   Mtc0: register write at edge; squashed mtc0 writes nothing.
//  o_redirect/o_squash/o_target combinational; all 0 when i_valid=0 or during reset.
//  mfc0 sees pre-edge value; mtc0 then mfc0 next cycle sees new value.
//  Count: +1 every cycle, wraps FFFF_FFFF->0; mtc0 Count overrides increment that cycle.
//  Timer: IP[7] set when Count==Compare (post-increment value); cleared only by mtc0 Compare,
//   which wins over a same-cycle match.
//  Reset mid-operation: all state returns to reset values immediately; pending sync data lost.
// CONFIGURATION
//  COP0_TIMER_EN defined: Count/Compare and IP[7] implemented as above.
//  Not defined: Count/Compare absent, read 0, writes ignored, IP[7] tied 0.
// TESTING
//  mtc0 Status=32'h0000_FF01, mfc0 Status next cycle -> o_rdata=32'h0000_FF01.
//  i_unknown=1 at i_pc=32'h40 -> redirect to 32'h180, squash=1; EPC=32'h40, EXL=1, ExcCode=10.
//  Same, then eret -> o_target=32'h40, squash=0; next cycle EXL=0.
//  IE=1, IM[2]=1, i_irq[0]=1 -> 2 cycles later at i_valid, redirect 32'h180, ExcCode=0;
//   second irq while EXL=1 -> no redirect.
//  TIMER_EN: Compare=5, Count=0, IM[7]=1, IE=1 -> IP[7] set after match, interrupt taken;
//   mtc0 Compare clears IP[7].
//  Exception with EXL=1 at pc=32'h80 -> redirect; EPC unchanged; reset asserted mid-handler -> all regs reset values.

Source files
------------

// File: rtl/cop0_exception_ctrl_if.sv
// Datapath <-> CP0 controller bus: commit flags, CP0 access and PC redirect/squash returns.
interface cop0_exception_ctrl_if #(
  parameter int unsigned IRQ_W = 5
);
  logic              i_valid;
  logic [31:0]       i_pc;
  logic              i_mtc0;
  logic              i_mfc0;
  logic              i_eret;
  logic              i_unknown;
  logic              i_overflow;
  logic [4:0]        i_cp0_addr;
  logic [31:0]       i_wdata;
  logic [IRQ_W-1:0]  i_irq;
  logic [31:0]       o_rdata;
  logic              o_redirect;
  logic [31:0]       o_target;
  logic              o_squash;
  logic              o_exl;

  modport master (
    output i_valid, i_pc, i_mtc0, i_mfc0, i_eret, i_unknown, i_overflow,
    output i_cp0_addr, i_wdata, i_irq,
    input  o_rdata, o_redirect, o_target, o_squash, o_exl
  );

  modport slave (
    input  i_valid, i_pc, i_mtc0, i_mfc0, i_eret, i_unknown, i_overflow,
    input  i_cp0_addr, i_wdata, i_irq,
    output o_rdata, o_redirect, o_target, o_squash, o_exl
  );
endinterface

// File: rtl/cop0_exception_ctrl.sv
// CP0 controller: Status/Cause/EPC plus exception, interrupt and eret sequencing.
// Define COP0_TIMER_EN to build the Count/Compare timer and Cause.IP[7].
module cop0_exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int unsigned IRQ_W      = 5
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  cop0_exception_ctrl_if.slave bus
);
  localparam logic [4:0] ExcRi = 5'd10;
  localparam logic [4:0] ExcOv = 5'd12;

  logic [IRQ_W-1:0] irq_s1_q, irq_s2_q;
  logic [7:0]       im_q, im_d;
  logic             exl_q, exl_d, ie_q, ie_d;
  logic [1:0]       ip_sw_q, ip_sw_d;
  logic [4:0]       exc_code_q, exc_code_d;
  logic [31:0]      epc_q, epc_d;

  logic        timer_pend;
  logic [31:0] count_val, compare_val;
  logic [7:0]  ip;
  logic        int_pend, take_exc, take_int, take_eret, take_mtc0;
  logic        unused_mfc0;

  assign unused_mfc0 = bus.i_mfc0;

  assign ip       = {timer_pend, irq_s2_q, ip_sw_q};
  assign int_pend = ie_q & ~exl_q & (|(ip & im_q));

  // Reset gating keeps the datapath from redirecting while CP0 state is being cleared.
  assign take_exc  = i_rst_n & bus.i_valid & (bus.i_unknown | bus.i_overflow);
  assign take_int  = i_rst_n & bus.i_valid & ~take_exc & int_pend;
  assign take_eret = i_rst_n & bus.i_valid & ~take_exc & ~take_int & bus.i_eret;
  assign take_mtc0 = i_rst_n & bus.i_valid & ~take_exc & ~take_int & ~bus.i_eret & bus.i_mtc0;

  assign bus.o_redirect = take_exc | take_int | take_eret;
  assign bus.o_squash   = take_exc | take_int;
  assign bus.o_exl      = exl_q;

  always_comb begin
    bus.o_target = 32'h0;
    if (take_exc || take_int) begin
      bus.o_target = EXC_VECTOR;
    end else if (take_eret) begin
      bus.o_target = epc_q;
    end
  end

  always_comb begin
    bus.o_rdata = 32'h0;
    case (bus.i_cp0_addr)
      5'd9:    bus.o_rdata = count_val;
      5'd11:   bus.o_rdata = compare_val;
      5'd12:   bus.o_rdata = {16'h0, im_q, 6'h0, exl_q, ie_q};
      5'd13:   bus.o_rdata = {16'h0, ip, 1'b0, exc_code_q, 2'b00};
      5'd14:   bus.o_rdata = epc_q;
      default: bus.o_rdata = 32'h0;
    endcase
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (take_exc) begin
      exl_d      = 1'b1;
      exc_code_d = bus.i_unknown ? ExcRi : ExcOv;
      // A nested exception keeps the original return address.
      if (!exl_q) epc_d = bus.i_pc;
    end else if (take_int) begin
      exl_d      = 1'b1;
      exc_code_d = 5'd0;
      epc_d      = bus.i_pc;
    end else if (take_eret) begin
      exl_d = 1'b0;
    end else if (take_mtc0) begin
      case (bus.i_cp0_addr)
        5'd12: begin
          im_d  = bus.i_wdata[15:8];
          exl_d = bus.i_wdata[1];
          ie_d  = bus.i_wdata[0];
        end
        5'd13:   ip_sw_d = bus.i_wdata[9:8];
        5'd14:   epc_d   = bus.i_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_s1_q   <= '0;
      irq_s2_q   <= '0;
      im_q       <= 8'h0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      ip_sw_q    <= 2'b00;
      exc_code_q <= 5'd0;
      epc_q      <= 32'h0;
    end else begin
      irq_s1_q   <= bus.i_irq;
      irq_s2_q   <= irq_s1_q;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

`ifdef COP0_TIMER_EN
  logic [31:0] count_q, count_d, compare_q;
  logic        timer_q, wr_count, wr_compare;

  assign wr_count   = take_mtc0 && (bus.i_cp0_addr == 5'd9);
  assign wr_compare = take_mtc0 && (bus.i_cp0_addr == 5'd11);
  assign count_d    = wr_count ? bus.i_wdata : count_q + 32'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q   <= 32'h0;
      compare_q <= 32'hFFFF_FFFF;
      timer_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_compare) begin
        compare_q <= bus.i_wdata;
        timer_q   <= 1'b0;
      end else if (count_d == compare_q) begin
        timer_q <= 1'b1;
      end
    end
  end

  assign timer_pend  = timer_q;
  assign count_val   = count_q;
  assign compare_val = compare_q;
`else
  assign timer_pend  = 1'b0;
  assign count_val   = 32'h0;
  assign compare_val = 32'h0;
`endif
endmodule

// File: tb/tb_cop0_exception_ctrl.sv
// Directed CP0 scenarios followed by randomized traffic against a register-level reference model.
module tb_cop0_exception_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cop0_exception_ctrl_if bus ();

  cop0_exception_ctrl dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

`ifdef COP0_TIMER_EN
  localparam bit TimerEn = 1'b1;
`else
  localparam bit TimerEn = 1'b0;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: architectural register contents.
  logic [31:0] m_status, m_epc, m_count, m_compare;
  logic [1:0]  m_sw;
  logic [4:0]  m_code, m_h1, m_h2;
  logic        m_timer;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return TimerEn ? m_count : 32'h0;
      5'd11:   return TimerEn ? m_compare : 32'h0;
      5'd12:   return m_status;
      5'd13:   return {16'h0, m_timer, m_h2, m_sw, 1'b0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_status = 0; m_epc = 0; m_count = 0; m_compare = 32'hFFFF_FFFF;
    m_sw = 0; m_code = 0; m_h1 = 0; m_h2 = 0; m_timer = 0;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit mt, input bit mf,
                       input bit er, input bit unk, input bit ovf, input logic [4:0] a,
                       input logic [31:0] wd);
    bus.i_valid = v; bus.i_pc = pc; bus.i_mtc0 = mt; bus.i_mfc0 = mf; bus.i_eret = er;
    bus.i_unknown = unk; bus.i_overflow = ovf; bus.i_cp0_addr = a; bus.i_wdata = wd;
  endtask

  // Called just after a falling edge; checks outputs, then advances model and DUT one cycle.
  task automatic step();
    logic [7:0]  ip;
    logic [4:0]  a;
    logic [31:0] wd, cnt_n, n_status, n_epc, n_compare;
    logic [1:0]  n_sw;
    logic [4:0]  n_code;
    logic        n_timer;
    bit          pend, exc, intr, er, mt;
    #1;
    a    = bus.i_cp0_addr;
    wd   = bus.i_wdata;
    ip   = {m_timer, m_h2, m_sw};
    pend = m_status[0] && !m_status[1] && ((ip & m_status[15:8]) != 8'h0);
    exc  = bus.i_valid && (bus.i_unknown || bus.i_overflow);
    intr = bus.i_valid && !exc && pend;
    er   = bus.i_valid && !exc && !intr && bus.i_eret;
    mt   = bus.i_valid && !exc && !intr && !bus.i_eret && bus.i_mtc0;
    check("redirect", 32'(bus.o_redirect), 32'(exc || intr || er));
    check("squash", 32'(bus.o_squash), 32'(exc || intr));
    if (exc || intr) check("target_vec", bus.o_target, 32'h0000_0180);
    else if (er) check("target_epc", bus.o_target, m_epc);
    else if (!bus.i_valid) check("target_idle", bus.o_target, 32'h0);
    check("exl", 32'(bus.o_exl), 32'(m_status[1]));
    check("rdata", bus.o_rdata, m_read(a));

    n_status = m_status; n_epc = m_epc; n_sw = m_sw; n_code = m_code;
    cnt_n = m_count + 32'd1;
    if (mt && a == 5'd9) cnt_n = wd;
    n_compare = m_compare; n_timer = m_timer;
    if (mt && a == 5'd11) begin
      n_compare = wd; n_timer = 1'b0;
    end else if (cnt_n == m_compare) begin
      n_timer = 1'b1;
    end
    if (!TimerEn) n_timer = 1'b0;
    if (exc) begin
      n_status[1] = 1'b1;
      n_code = bus.i_unknown ? 5'd10 : 5'd12;
      if (!m_status[1]) n_epc = bus.i_pc;
    end else if (intr) begin
      n_status[1] = 1'b1; n_code = 5'd0; n_epc = bus.i_pc;
    end else if (er) begin
      n_status[1] = 1'b0;
    end else if (mt) begin
      if (a == 5'd12) n_status = wd & 32'h0000_FF03;
      if (a == 5'd13) n_sw = wd[9:8];
      if (a == 5'd14) n_epc = wd;
    end
    @(posedge clk);
    m_h2 = m_h1; m_h1 = bus.i_irq;
    m_status = n_status; m_epc = n_epc; m_sw = n_sw; m_code = n_code;
    m_count = cnt_n; m_compare = n_compare; m_timer = n_timer;
    @(negedge clk);
  endtask

  task automatic idle_rd(input logic [4:0] a);
    drive(0, 32'h0, 0, 1, 0, 0, 0, a, 32'h0);
  endtask

  task automatic expect_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    idle_rd(a);
    #1 check(tag, bus.o_rdata, exp);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1, 32'h44, 0, 1, 1, 0, 0, 5'd12, 32'h0);
    #1;
    check("rst_redirect", 32'(bus.o_redirect), 32'h0);
    check("rst_squash", 32'(bus.o_squash), 32'h0);
    check("rst_exl", 32'(bus.o_exl), 32'h0);
    check("rst_status", bus.o_rdata, 32'h0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    idle_rd(5'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] addrs [5] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    logic [4:0] a;
    logic [31:0] wd;
    bus.i_irq = '0;
    idle_rd(5'd12);
    m_reset();
    @(negedge clk);
    check("reset_status", bus.o_rdata, 32'h0);
    check("reset_exl", 32'(bus.o_exl), 32'h0);
    bus.i_cp0_addr = 5'd11;
    #1 check("reset_compare", bus.o_rdata, TimerEn ? 32'hFFFF_FFFF : 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, 32'h10, 1, 0, 0, 0, 0, 5'd12, 32'h0000_FF01);
    step();
    expect_rd("status_rb", 5'd12, 32'h0000_FF01);

    drive(1, 32'h40, 0, 0, 0, 1, 0, 5'd0, 32'h0);
    #1 check("ri_target", bus.o_target, 32'h180);
    check("ri_squash", 32'(bus.o_squash), 32'h1);
    step();
    expect_rd("ri_epc", 5'd14, 32'h40);
    expect_rd("ri_cause", 5'd13, 32'h28);
    check("ri_exl", 32'(bus.o_exl), 32'h1);

    drive(1, 32'h300, 0, 0, 1, 0, 0, 5'd0, 32'h0);
    #1 check("eret_target", bus.o_target, 32'h40);
    check("eret_squash", 32'(bus.o_squash), 32'h0);
    step();
    check("eret_exl", 32'(bus.o_exl), 32'h0);

    bus.i_irq = 5'b00001;
    idle_rd(5'd0); step();
    idle_rd(5'd0); step();
    drive(1, 32'h100, 0, 0, 0, 0, 0, 5'd0, 32'h0);
    #1 check("irq_redirect", 32'(bus.o_redirect), 32'h1);
    step();
    expect_rd("irq_cause", 5'd13, 32'h0000_0400);
    drive(1, 32'h104, 0, 0, 0, 0, 0, 5'd0, 32'h0);
    #1 check("irq_masked_exl", 32'(bus.o_redirect), 32'h0);
    step();
    drive(1, 32'h80, 0, 0, 0, 1, 0, 5'd0, 32'h0);
    #1 check("nested_redirect", 32'(bus.o_redirect), 32'h1);
    step();
    expect_rd("nested_epc", 5'd14, 32'h100);
    bus.i_irq = '0;
    do_reset();
    expect_rd("post_rst_epc", 5'd14, 32'h0);
    expect_rd("post_rst_cause", 5'd13, 32'h0);

`ifdef COP0_TIMER_EN
    drive(1, 32'h10, 1, 0, 0, 0, 0, 5'd12, 32'h0000_8001); step();
    drive(1, 32'h14, 1, 0, 0, 0, 0, 5'd9, 32'h0); step();
    drive(1, 32'h18, 1, 0, 0, 0, 0, 5'd11, 32'h5); step();
    for (int i = 0; i < 5; i++) begin
      idle_rd(5'd13); step();
    end
    idle_rd(5'd13);
    #1 check("timer_ip7", 32'(bus.o_rdata[15]), 32'h1);
    drive(1, 32'h200, 0, 0, 0, 0, 0, 5'd0, 32'h0);
    #1 check("timer_redirect", 32'(bus.o_redirect), 32'h1);
    step();
    drive(1, 32'h180, 1, 0, 0, 0, 0, 5'd11, 32'd100); step();
    idle_rd(5'd13);
    #1 check("timer_clr", 32'(bus.o_rdata[15]), 32'h0);
    step();
    drive(1, 32'h184, 0, 0, 1, 0, 0, 5'd0, 32'h0); step();
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      if ($urandom_range(0, 7) == 0) bus.i_irq = 5'($urandom);
      a = ($urandom_range(0, 4) != 0) ? addrs[$urandom_range(0, 4)] : 5'($urandom);
      wd = $urandom;
      if (a == 5'd12) wd[1] = ($urandom_range(0, 3) == 0);
      if (a == 5'd11 && $urandom_range(0, 1) == 0) wd = m_count + $urandom_range(2, 20);
      drive($urandom_range(0, 4) != 0, {$urandom, 2'b00} >> 2 << 2,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 39) == 0, a, wd);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
